adc_emulator: RTL and testbench
===============================

ADC_EMULATOR -- requirements
Module: adc_emulator

Interface
REQ-001 Parameter SYNC_STAGES, default 2, meaning: flip-flop depth of the CS/SCK input synchronizers (legal 2..3).
REQ-002 clk  input  1  50 MHz system clock; all logic on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 CS  input  1  chip select from the ADC master; active low; asynchronous to clk.
REQ-005 SCK  input  1  serial clock from the master, at most 2.5 MHz; asynchronous to clk.
REQ-006 SDO  output  1  serial data to the master, registered, always driven (never high-Z).
REQ-007 sample_in  input  12  next conversion value, unsigned.
REQ-008 load  input  1  single-cycle strobe; writes sample_in into the holding register.
REQ-009 busy  output  1  high while a frame is in progress (state not IDLE/WAIT_HIGH).
REQ-010 frame_done  output  1  one-clk pulse on a complete frame end.
REQ-011 short_frame  output  1  one-clk pulse on an aborted frame end.

Function
REQ-012 CS and SCK shall each pass through a SYNC_STAGES flip-flop synchronizer, then one edge-detect register; all decisions use synchronized values only.
REQ-013 FSM states: WAIT_HIGH, IDLE, LEAD, DATA, TAIL.
REQ-014 WAIT_HIGH -> IDLE when synchronized CS is high; used after reset so a frame already in progress is never joined mid-way.
REQ-015 IDLE -> LEAD on synchronized CS falling edge; same cycle, the 12-bit shift register loads the holding register and the 4-bit falling-edge count n clears to 0.
REQ-016 n shall increment on each synchronized SCK falling edge while CS is low, saturating at 15.
REQ-017 SDO value by n: n<2 -> 0 (leading zeros); 2<=n<=13 -> bit (13-n) of the captured word, MSB first; n>=14 -> 0.
REQ-018 LEAD -> DATA when n reaches 2; DATA -> TAIL when n reaches 14.
REQ-019 SDO shall update on the clk cycle after the synchronized SCK falling edge is detected; total latency from SCK pin fall to SDO change is SYNC_STAGES+2 clk cycles max (4 at default), well inside half an SCK period.
REQ-020 SDO shall be 0 whenever the state is WAIT_HIGH or IDLE.
REQ-021 CS rising edge in TAIL: frame_done pulses one cycle, state -> IDLE.
REQ-022 CS rising edge in LEAD or DATA: short_frame pulses one cycle, SDO -> 0, state -> IDLE; the holding register is unchanged.
REQ-023 SCK edges while CS is high shall be ignored.
REQ-024 load shall write sample_in into the holding register in any state; a load during a frame affects only the next frame.
REQ-025 load asserted in the same cycle as the CS falling edge: the shift register captures the old holding value; the new value is used next frame.
REQ-026 Simultaneous synchronized CS rising edge and SCK falling edge: the CS edge wins; n does not increment.

Reset
REQ-027 While rst is high: SDO=0, busy=0, frame_done=0, short_frame=0, holding and shift registers=0, n=0, synchronizers cleared to CS=1/SCK=0, state=WAIT_HIGH.
REQ-028 rst asserted mid-frame shall drive SDO to 0 immediately (asynchronously), with no pulse on frame_done or short_frame.

Configuration
REQ-029 Macro ADC_EMULATOR_RAMP_EN.
- Defined: the holding register is an internal 12-bit ramp that increments by 1 on every frame_done pulse and wraps 4095 -> 0; sample_in and load are ignored.
- Undefined: the holding register is written only by load as in REQ-024; no ramp logic exists.

Verification
REQ-030 Load 12'hA5C, then drive an 18-SCK frame at 2.5 MHz (CS low at an SCK rise) -> master samples on rises after falls 2..13 read 1010_0101_1100; frame_done pulses once; SDO=0 after fall 14.
REQ-031 Raise CS after 7 SCK falls -> short_frame pulses once, SDO=0, busy=0; next full frame returns the same holding value.
REQ-032 Assert rst for 3 clk after 5 falls, with CS still low -> SDO=0 at once; no SDO activity until CS goes high and then falls again.
REQ-033 Pulse load with 12'h123 during fall 8 of a frame carrying 12'hFFF -> current frame reads FFF; next frame reads 123.
REQ-034 Toggle SCK 10 times with CS high -> SDO stays 0, busy stays 0, no pulses.
REQ-035 With ADC_EMULATOR_RAMP_EN defined, run 4097 complete frames -> words read 0,1,2,...,4095,0.

Source files
------------

// File: rtl/adc_emulator.sv
// adc_emulator: SPI-style ADC slave model. Emits 2 leading zeros, a 12-bit
// word MSB first, then trailing zeros, one bit per SCK falling edge.
// CS and SCK are asynchronous to clk and are synchronized before use.
// Optional build macro: ADC_EMULATOR_RAMP_EN replaces the load-written holding
// register with a free-running ramp that advances on every completed frame.
//
// Handshake: there is no valid/ready pair; load is a single-cycle strobe that
// is always accepted, and frame_done/short_frame are single-cycle pulses with
// no back-pressure.
module adc_emulator #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic        SCK,
    output logic        SDO,
    input  logic [11:0] sample_in,
    input  logic        load,
    output logic        busy,
    output logic        frame_done,
    output logic        short_frame,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        LEAD      = 3'd2,
        DATA      = 3'd3,
        TAIL      = 3'd4
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] cs_sync, sck_sync;
    logic                   cs_d, sck_d, armed;
    logic                   cs_s, sck_s, cs_fall, cs_rise, sck_fall;
    logic [3:0]             n, n_next, bit_idx;
    logic [11:0]            hold, shift_reg;
    logic                   shift_load, done_next, short_next, sdo_next;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_fall = sck_d & ~sck_s;

    assign busy      = (state == LEAD) || (state == DATA) || (state == TAIL);
    assign state_dbg = state;

    // Input synchronizers plus one edge-detect stage. 'armed' blocks the
    // WAIT_HIGH exit until the chain has sampled the real pin at least once,
    // so the reset value of the chain can never look like an idle-high CS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            cs_d     <= 1'b1;
            sck_d    <= 1'b0;
            armed    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CS};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_d     <= cs_s;
            sck_d    <= sck_s;
            armed    <= 1'b1;
        end
    end

    // Next-state, bit counter and frame-end pulse decisions.
    always_comb begin
        state_next = state;
        n_next     = n;
        shift_load = 1'b0;
        done_next  = 1'b0;
        short_next = 1'b0;
        case (state)
            WAIT_HIGH: begin
                if (armed && (&cs_sync)) state_next = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_next = LEAD;
                    n_next     = 4'd0;
                    shift_load = 1'b1;
                end
            end
            LEAD, DATA, TAIL: begin
                // A CS rise takes priority over a coincident SCK fall.
                if (cs_rise) begin
                    state_next = IDLE;
                    if (state == TAIL) done_next = 1'b1;
                    else               short_next = 1'b1;
                end else begin
                    if (sck_fall && !cs_s && (n != 4'd15)) n_next = n + 4'd1;
                    if ((state == LEAD) && (n_next >= 4'd2))
                        state_next = DATA;
                    else if ((state == DATA) && (n_next >= 4'd14))
                        state_next = TAIL;
                end
            end
            default: state_next = WAIT_HIGH;
        endcase
    end

    // SDO is computed from the next state/count so it moves one clk after
    // the synchronized SCK fall is seen, and drops with the frame abort.
    always_comb begin
        sdo_next = 1'b0;
        bit_idx  = 4'd13 - n_next;
        if (((state_next == LEAD) || (state_next == DATA) || (state_next == TAIL)) &&
            (n_next >= 4'd2) && (n_next <= 4'd13))
            sdo_next = shift_reg[bit_idx];
    end

    // FSM state, counter, captured word and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_HIGH;
            n           <= 4'd0;
            shift_reg   <= 12'd0;
            SDO         <= 1'b0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            state       <= state_next;
            n           <= n_next;
            if (shift_load) shift_reg <= hold;
            SDO         <= sdo_next;
            frame_done  <= done_next;
            short_frame <= short_next;
        end
    end

`ifdef ADC_EMULATOR_RAMP_EN
    logic unused_ramp_inputs;
    assign unused_ramp_inputs = ^{sample_in, load};

    // Ramp source: advance once per completed frame, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            hold <= 12'd0;
        else if (done_next) hold <= hold + 12'd1;
    end
`else
    // Holding register: written by load at any time; a frame in flight keeps
    // the word it captured at its CS fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       hold <= 12'd0;
        else if (load) hold <= sample_in;
    end
`endif

endmodule

// File: tb/tb_adc_emulator.sv
// Directed testbench for adc_emulator: a 2.5 MHz SCK master (idle high)
// that samples SDO on each SCK rise, with immediate-assertion checks.
module tb_adc_emulator;

    localparam logic [2:0] ST_WAIT_HIGH = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b1;
    logic        sck = 1'b1;
    logic        sdo;
    logic [11:0] sample_in = 12'd0;
    logic        load = 1'b0;
    logic        busy, frame_done, short_frame;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int short_cnt = 0;

    adc_emulator #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .CS(cs), .SCK(sck), .SDO(sdo),
        .sample_in(sample_in), .load(load), .busy(busy),
        .frame_done(frame_done), .short_frame(short_frame),
        .state_dbg(state_dbg)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // Pulse counters (a pulse wider than one cycle counts more than once)
    always @(negedge clk) begin
        if (frame_done)  done_cnt  = done_cnt + 1;
        if (short_frame) short_cnt = short_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [11:0] v);
        @(negedge clk);
        sample_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // One frame: CS low, nfalls SCK periods (400 ns), CS high. load_at = 0
    // pulses load in the cycle the DUT detects the CS fall; load_at = k pulses
    // it during fall k; any other value disables the load.
    task automatic run_frame(input int nfalls, input int load_at,
                             input logic [11:0] load_val, output logic [11:0] word);
        word = 12'd0;
        @(negedge clk);
        cs = 1'b0;
        if (load_at == 0) begin
            repeat (2) @(negedge clk);
            sample_in = load_val;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            repeat (7) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
        for (int i = 1; i <= nfalls; i++) begin
            sck = 1'b0;
            if (i == load_at) begin
                @(negedge clk);
                sample_in = load_val;
                load = 1'b1;
                @(negedge clk);
                load = 1'b0;
                repeat (8) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
            if (i >= 2 && i <= 13) word[13-i] = sdo;
            if (i == 1) check("busy_in_frame", busy, 1);
            if (i == 14) check("sdo_after_fall14", sdo, 0);
            sck = 1'b1;
            repeat (10) @(negedge clk);
        end
        cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int nfalls, input int load_at,
                               input logic [11:0] load_val, input logic [11:0] exp_word);
        logic [11:0] word;
        int d0, s0;
        d0 = done_cnt;
        s0 = short_cnt;
        run_frame(nfalls, load_at, load_val, word);
        if (nfalls >= 14) begin
            check({tag, "_word"}, word, exp_word);
            check({tag, "_done"}, done_cnt - d0, 1);
            check({tag, "_short"}, short_cnt - s0, 0);
        end else begin
            check({tag, "_done"}, done_cnt - d0, 0);
            check({tag, "_short"}, short_cnt - s0, 1);
        end
        check({tag, "_sdo_end"}, sdo, 0);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_state_end"}, state_dbg, ST_IDLE);
    endtask

    initial begin
        int d0, s0;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sdo", sdo, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_short_frame", short_frame, 0);
        check("rst_state", state_dbg, ST_WAIT_HIGH);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_state", state_dbg, ST_IDLE);

`ifdef ADC_EMULATOR_RAMP_EN
        check_frame("ramp0", 18, -1, 12'd0, 12'h000);
        check_frame("ramp1", 18, -1, 12'd0, 12'h001);
        check_frame("ramp2", 18, -1, 12'd0, 12'h002);
`else
        // Basic frame
        load_word(12'hA5C);
        check_frame("a5c", 18, -1, 12'd0, 12'hA5C);

        // Aborted frame after 7 falls, then the same word again
        check_frame("abort7", 7, -1, 12'd0, 12'd0);
        check_frame("after_abort", 18, -1, 12'd0, 12'hA5C);

        // Load during fall 8 only affects the next frame
        load_word(12'hFFF);
        check_frame("fff_with_load", 18, 8, 12'h123, 12'hFFF);
        check_frame("next_123", 18, -1, 12'd0, 12'h123);

        // Load coincident with the CS fall: old word this frame, new word next
        check_frame("coincident_load", 18, 0, 12'h3C6, 12'h123);
        check_frame("next_3c6", 18, -1, 12'd0, 12'h3C6);

        // SCK activity with CS high is ignored
        d0 = done_cnt;
        s0 = short_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sck = 1'b0;
            repeat (5) @(negedge clk);
            check("cs_high_sdo", sdo, 0);
            check("cs_high_busy", busy, 0);
            sck = 1'b1;
            repeat (5) @(negedge clk);
        end
        check("cs_high_done", done_cnt - d0, 0);
        check("cs_high_short", short_cnt - s0, 0);

        // Reset mid-frame after 5 falls with CS held low
        load_word(12'hFFF);
        d0 = done_cnt;
        s0 = short_cnt;
        @(negedge clk);
        cs = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 18; i++) begin
            sck = 1'b0;
            repeat (10) @(negedge clk);
            if (i == 5) begin
                check("sdo_before_rst", sdo, 1);
                rst = 1'b1;
                #1;
                check("sdo_async_rst", sdo, 0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end else if (i > 5) begin
                check("sdo_quiet_after_rst", sdo, 0);
                check("busy_quiet_after_rst", busy, 0);
            end
            sck = 1'b1;
            repeat (10) @(negedge clk);
        end
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_done", done_cnt - d0, 0);
        check("rst_mid_short", short_cnt - s0, 0);
        check("rst_mid_state", state_dbg, ST_IDLE);
        // Holding register was cleared by the reset
        check_frame("after_rst", 18, -1, 12'd0, 12'h000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
